// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, default latencies and FSM state encoding.
package md_pkg;

    localparam logic [1:0] MD_MULTU = 2'd0;
    localparam logic [1:0] MD_MULT  = 2'd1;
    localparam logic [1:0] MD_DIVU  = 2'd2;
    localparam logic [1:0] MD_DIV   = 2'd3;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath.
// Ports: op_i, a_i, b_i in; hi_o, lo_o, div_zero_o out.
module md_arith
    import md_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    logic [63:0]        uprod;
    logic signed [63:0] sprod;
    logic [31:0]        bd;
    logic               ovf;

    // Substitute 1 for a zero divisor so the divider never
    // sees x/0; the result is discarded by the caller.
    assign div_zero_o = (b_i == 32'd0);
    assign bd         = div_zero_o ? 32'd1 : b_i;
    assign ovf        = (a_i == 32'h8000_0000) &&
                        (b_i == 32'hFFFF_FFFF);

    assign uprod = {32'd0, a_i} * {32'd0, b_i};
    assign sprod = $signed(a_i) * $signed(b_i);

    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        unique case (op_i)
            MD_MULTU: begin
                hi_o = uprod[63:32];
                lo_o = uprod[31:0];
            end
            MD_MULT: begin
                hi_o = sprod[63:32];
                lo_o = sprod[31:0];
            end
            MD_DIVU: begin
                hi_o = a_i % bd;
                lo_o = a_i / bd;
            end
            MD_DIV: begin
                // Most-negative / -1 overflows; define it explicitly.
                if (ovf) begin
                    hi_o = 32'd0;
                    lo_o = 32'h8000_0000;
                end else begin
                    hi_o = $signed(a_i) % $signed(bd);
                    lo_o = $signed(a_i) / $signed(bd);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO registers.
// Ports: clk, rst_n, start, op, mdwe, hilo, mdread, cancel,
// a, b in; busy, md_out out.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        mdwe,
    input  logic        hilo,
    input  logic        mdread,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam int LMAX = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(LMAX + 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        latch;
    logic [31:0] r_hi, r_lo;
    logic        r_dz;

    md_arith u_arith (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .hi_o       (r_hi),
        .lo_o       (r_lo),
        .div_zero_o (r_dz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        latch   = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (start && !cancel) begin
                    latch   = 1'b1;
                    state_d = MD_BUSY;
                    cnt_d   = op[1] ? CW'(DIV_CYCLES - 1)
                                    : CW'(MULT_CYCLES - 1);
                end else if (mdwe && !cancel) begin
                    if (hilo) hi_d = a;
                    else      lo_d = a;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                    // Divide by zero leaves HI/LO untouched.
                    if (!(op_q[1] && r_dz)) begin
                        hi_d = r_hi;
                        lo_d = r_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULTU;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (latch) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    assign busy   = (state_q == MD_BUSY);
    assign md_out = mdread ? lo_q : hi_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide execution unit with the architectural HI/LO registers, located in the E stage of the pipeline.
- Consumes the E-stage control strobes from the mult/div instruction decoder: start, op, mdwe, hilo and mdread.
- Runs mult/multu/div/divu over a fixed number of cycles and accepts mthi/mtlo writes.
- Returns HI or LO for mfhi/mflo, and raises busy so the hazard unit stalls dependent mult/div instructions.

Parameters:
- MULT_CYCLES, 5: number of busy cycles for mult/multu.
- DIV_CYCLES, 10: number of busy cycles for div/divu.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a mult/div operation this cycle.
- op  input  2  operation select: 0 multu, 1 mult, 2 divu, 3 div.
- mdwe  input  1  HI/LO write strobe (mthi/mtlo).
- hilo  input  1  write target when mdwe=1: 1 selects HI, 0 selects LO.
- mdread  input  1  read select: 1 selects LO (mflo), 0 selects HI (mfhi).
- cancel  input  1  exception or flush in a later stage; suppresses start and mdwe in this cycle.
- a  input  32  rs operand; also the mthi/mtlo data.
- b  input  32  rt operand.
- busy  output  1  operation in flight.
- md_out  output  32  HI or LO, selected by mdread.

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, FSM=IDLE. Reset applies immediately and asynchronously.
- Reset during BUSY abandons the operation; HI/LO end as 0.
- FSM has two states, IDLE and BUSY.
- Launch from IDLE: when start=1 and cancel=0 at clock edge T:
  - latch op, a and b;
  - busy=1 for the cycles following edges T through T+LAT-1, where LAT is MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3);
  - HI/LO are written at edge T+LAT; busy=0 from that edge onward;
  - md_out shows the new value in the cycle after edge T+LAT.
- Counter: loaded with LAT-1 at launch and decremented in BUSY. At 0 the unit commits the result and returns to IDLE.
- Ignored inputs: start while BUSY is ignored (upstream must stall); start or mdwe with cancel=1 is ignored.
- mdwe=1 (and cancel=0) in IDLE writes a to HI (hilo=1) or LO (hilo=0) at the next edge.
- mdwe while BUSY is ignored; the hazard unit must prevent it.
- If start and mdwe are both asserted in IDLE, start takes priority and mdwe is dropped.
- md_out = mdread ? LO : HI. It is combinational from the current registers, with no bypass of a same-cycle write.
- Multiplication:
  - multu uses a 64-bit unsigned product; mult uses a 64-bit two's-complement signed product.
  - HI = product[63:32], LO = product[31:0].
- Division:
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - div of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero (b=0, div or divu) still runs DIV_CYCLES with busy asserted, but HI/LO are left unchanged at commit.
- The result is computed from the operands latched at launch. Changes on a/b during BUSY have no effect.

Decomposition:
- Shared package md_pkg holds:
  - op encodings MD_MULTU=0, MD_MULT=1, MD_DIVU=2, MD_DIV=3;
  - MULT_CYCLES and DIV_CYCLES defaults;
  - FSM state encoding for IDLE and BUSY.
- One combinational sub-module, md_arith, takes op and the latched operands. It returns {hi,lo} and a div_zero flag.
- md_unit holds the FSM, counter, operand latches and HI/LO registers.

Test Plan:
- multu with a=0xFFFFFFFF, b=2: busy high for exactly 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE; mfhi/mflo read these values.
- mult with a=0xFFFFFFFD (-3), b=5: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div with a=0xFFFFFFF9 (-7), b=2: busy high for exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mthi with a=0x12345678, then divu with b=0: busy for 10 cycles; afterwards HI=0x12345678 and LO keep their prior values.
- Overlap and cancel: start while BUSY is ignored; a/b changed mid-op does not alter the result; start with cancel=1 leaves busy=0 and HI/LO unchanged.
- Reset: drive rst_n low in the 3rd busy cycle of mult; busy=0 and HI=LO=0 immediately, without waiting for a clock edge.
